// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the register file and ALU.
// WIDTH must match the ALU data width; REG_COUNT follows from ADDR_W.
package mips_pkg;

    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  word_t;

    localparam reg_addr_t ZERO_REG = '0;

    // True when a read address refers to the staged write; r0 never matches.
    function automatic logic addr_match(input logic      valid,
                                        input reg_addr_t staged,
                                        input reg_addr_t rd);
        return valid && (staged == rd) && (rd != ZERO_REG);
    endfunction

endpackage : mips_pkg

// File: rtl/wb_stage.sv
// Write-back staging register: holds one ALU result for a cycle before it
// is committed to the register array, and reports read-address matches.
module wb_stage
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    output logic      wb_valid,
    output reg_addr_t wb_addr,
    output word_t     wb_data,
    output logic      match_a,
    output logic      match_b
);

    // Capture a write request; writes to r0 are dropped here so they never commit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, keeping commit and capture ordered.
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= ZERO_REG;
            wb_data  <= '0;
        end else begin
            wb_valid <= wr_en && (wr_addr != ZERO_REG);
            if (wr_en) begin
                wb_addr <= wr_addr;
                wb_data <= wr_data;
            end
        end
    end

    // Address compare against the staged write for each read port.
    always_comb begin
        match_a = addr_match(wb_valid, wb_addr, rd_addr_a);
        match_b = addr_match(wb_valid, wb_addr, rd_addr_b);
    end

endmodule : wb_stage

// File: rtl/reg_file_wb.sv
// Register file with a one-cycle write-back stage and a zero-status flag.
// Two combinational read ports feed ALU A/B; the write port takes ALU_out.
// Build option: define REGFILE_BYPASS_EN to forward the staged write to the
// read ports (hazard outputs then tie low); otherwise hazards flag the match.
module reg_file_wb
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    output word_t     rd_data_a,
    output word_t     rd_data_b,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  logic      zero_in,
    output logic      zero_q,
    output logic      hazard_a,
    output logic      hazard_b,
    output logic      wb_busy
);

    word_t     regs [REG_COUNT];
    logic      wb_valid;
    reg_addr_t wb_addr;
    word_t     wb_data;
    logic      match_a;
    logic      match_b;

    wb_stage u_wb_stage (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .match_a   (match_a),
        .match_b   (match_b)
    );

    // Commit the staged write; reset clears every register and drops the stage.
    always_ff @(posedge clk) begin
        // NOTE: the array is cleared on reset because software relies on all
        // registers reading 0 afterwards; this forces flops rather than a RAM.
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && (wb_addr != ZERO_REG)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Zero status follows the ALU flag whenever a write is requested, even to r0.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (wr_en) begin
            zero_q <= zero_in;
        end
    end

    // Read muxes: r0 is hard-wired to 0, staged data forwarded when enabled.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : regs[rd_addr_b];
        hazard_a  = 1'b0;
        hazard_b  = 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (match_a) rd_data_a = wb_data;
        if (match_b) rd_data_b = wb_data;
`else
        hazard_a  = match_a;
        hazard_b  = match_b;
`endif
    end

    assign wb_busy = wb_valid;

endmodule : reg_file_wb
